imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_word_packer.sv | 59 +++++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared definitions for the instruction-memory boot loader.
//            Holds the loader state encoding, the image header width and
//            the byte/word packing constants.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int unsigned HDR_W          = 16;  // header word-count width
  localparam int unsigned WORD_W         = 32;  // instruction word width
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_LAST   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Purpose  : Packs a big-endian byte stream into 32-bit words. The first
//            byte of a word lands in [31:24], the last in [7:0].
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            clear_i      - synchronous clear of the byte index
//            valid_i      - a byte is accepted this cycle
//            byte_i       - accepted byte
//            word_o       - assembled word (valid together with last_o)
//            last_o       - this accepted byte completes a word
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);

  localparam int unsigned SHIFT_W = (BYTES_PER_WORD - 1) * 8;
  localparam logic [BYTE_IDX_W-1:0] C_LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;

  // The final byte is combined directly with the stored bytes, so the
  // full word is available in the same cycle it is accepted.
  assign last_o = valid_i && (idx_q == C_LAST_IDX);
  assign word_o = {shift_q, byte_i};

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (valid_i) begin
      shift_d = {shift_q[SHIFT_W-9:0], byte_i};
      idx_d   = last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule : imem_word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader that receives a byte-stream image (16-bit
//            big-endian word count followed by big-endian 32-bit words),
//            writes it into instruction memory and holds the CPU in reset
//            until the image is complete.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            rx_data/rx_valid/rx_ready - incoming byte handshake
//            reload                - restart a load from DONE or ERROR
//            imem_we/addr/wd       - instruction memory write port
//            cpu_rst               - core reset, high while loading
//            done / err            - load complete / header too large
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  // Word index spans 0..DEPTH so it can never wrap for a legal image.
  localparam int unsigned WIDX_W = $clog2(DEPTH + 1);

  state_e               state_q, state_d;
  logic [7:0]           hdr_hi_q, hdr_hi_d;
  logic [HDR_W-1:0]     count_q, count_d;
  logic [WIDX_W-1:0]    widx_q, widx_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [WORD_W-1:0]    wd_q, wd_d;

  logic                 accept;
  logic                 pk_valid;
  logic                 pk_clear;
  logic [WORD_W-1:0]    pk_word;
  logic                 pk_last;
  logic [HDR_W-1:0]     hdr_count;
  logic                 final_word;

  assign rx_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                    (state_q == ST_DATA);
  assign accept   = rx_valid && rx_ready;

  // Packer only sees bytes in DATA; outside DATA its byte index is held
  // at zero so any partial word is discarded.
  assign pk_valid = accept && (state_q == ST_DATA);
  assign pk_clear = (state_q != ST_DATA);

  assign hdr_count  = {hdr_hi_q, rx_data};
  assign final_word = (HDR_W'(widx_q) == (count_q - 1'b1));

  imem_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (pk_clear),
    .valid_i (pk_valid),
    .byte_i  (rx_data),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    count_d  = count_q;
    widx_d   = widx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wd_d     = wd_q;
    case (state_q)
      ST_HDR_HI: begin
        if (accept) begin
          hdr_hi_d = rx_data;
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          count_d = hdr_count;
          widx_d  = '0;
          if (hdr_count == '0) begin
            state_d = ST_DONE;
          end else if (32'(hdr_count) > DEPTH) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_last) begin
          we_d   = 1'b1;
          wd_d   = pk_word;
          addr_d = ADDR_BASE + (32'(widx_q) << 2);
          if (final_word) begin
            state_d = ST_LAST;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      ST_LAST: begin
        // Occupies exactly the final write cycle so cpu_rst drops after it.
        state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d  = ST_HDR_HI;
          hdr_hi_d = '0;
          count_d  = '0;
          widx_d   = '0;
        end
      end
      default: begin
        state_d = ST_HDR_HI;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HDR_HI;
      hdr_hi_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= ADDR_BASE;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      hdr_hi_q <= hdr_hi_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign cpu_rst   = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERROR);

endmodule : imem_loader
`default_nettype wire
